uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo_mem.sv | 33 +++
 rtl/uart_rx_fifo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds default character width and FIFO depth, the UART bit-period
// oversample constant, and a helper that sizes occupancy counters.
package uart_pkg;

    localparam int unsigned UART_WIDTH = 8;   // bits per character
    localparam int unsigned FIFO_DEPTH = 16;  // receive FIFO entries
    localparam int unsigned BITLEN     = 16;  // oversample clocks per UART bit

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM for the UART receive FIFO.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - asynchronous read data at raddr
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = UART_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO.
// Captures one character per rising edge of the receiver's data-ready level
// and buffers it in a first-word-fall-through FIFO.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   in_data       - received character
//   in_flag       - receiver data-ready level
//   out_data      - head-of-FIFO character (holds last value when empty)
//   out_valid     - FIFO not empty
//   out_ready     - consumer accepts head character
//   count         - occupancy 0..DEPTH
//   full          - count == DEPTH
//   overflow      - sticky, set when a character is dropped
//   clr_overflow  - clears overflow (a same-cycle drop wins)
//   level_hit     - count >= THRESHOLD
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH     = UART_WIDTH,
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned THRESHOLD = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_flag,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic                        level_hit
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] THR_CNT  = CW'(THRESHOLD);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             flag_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] ram_rdata;

    logic push_req;
    logic push_ok;
    logic pop;
    logic drop;

    // Status flags come from the registered count only.
    assign full      = (count_q == FULL_CNT);
    assign out_valid = (count_q != '0);
    assign level_hit = (count_q >= THR_CNT);
    assign count     = count_q;
    assign overflow  = overflow_q;

    // One push per character: edge of the data-ready level.
    assign push_req = in_flag & ~flag_q;
    assign pop      = out_valid & out_ready;
    // When full, a simultaneous pop frees the slot being written.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // While empty the RAM slot at rd_ptr is stale, so show the last head instead.
    assign out_data = out_valid ? ram_rdata : hold_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // Reset high so a level held across reset is not taken as a new character.
            flag_q     <= 1'b1;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            flag_q     <= in_flag;
            hold_q     <= out_data;
        end
    end

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok & ~rst),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

endmodule
